// File: rtl/rvee_mem_pkg.sv
// Shared types and constants for the RVee memory stage.
package rvee_mem_pkg;

    localparam int unsigned XLEN_SUPPORTED = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Loads win if both load and store flags are somehow set.
    function automatic logic [3:0] mem_exc_cause(input logic is_load, input logic is_fault);
        logic [3:0] cause;
        if (is_load) begin
            cause = is_fault ? EXC_LD_FAULT : EXC_LD_MISALIGN;
        end else begin
            cause = is_fault ? EXC_ST_FAULT : EXC_ST_MISALIGN;
        end
        return cause;
    endfunction

endpackage

// File: rtl/rvee_mem_align.sv
// Combinational alignment helper: misalign detect, store lane steering, load lane extract.
module rvee_mem_align
    import rvee_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            sext,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic            misaligned,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] lane_s;

    // Store steering and misalignment; size 3 falls through to word.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = st_data;
        case (mem_size_e'(size))
            MEM_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            MEM_H: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << addr_lo;
                wdata      = {2{st_data[15:0]}};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata      = st_data;
            end
        endcase
    end

    // Load lane extraction with zero or sign extension.
    always_comb begin
        lane_s  = rdata >> {addr_lo, 3'b000};
        ld_data = lane_s;
        case (mem_size_e'(size))
            MEM_B:   ld_data = {{(XLEN-8){lane_s[7] & sext}}, lane_s[7:0]};
            MEM_H:   ld_data = {{(XLEN-16){lane_s[15] & sext}}, lane_s[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/rvee_mem.sv
// RVee memory stage: single-outstanding data bus FSM, writeback and precise exceptions.
module rvee_mem
    import rvee_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_rd_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic            ex_mem_load,
    input  logic            ex_mem_store,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_sext,
    output logic            ex_done,
    output logic            ex_idle,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    input  logic            dbus_err,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exception,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_pc,
    output logic [XLEN-1:0] exc_tval
);

    if (XLEN != XLEN_SUPPORTED) begin : g_xlen_check
        $error("rvee_mem: only XLEN=32 is supported");
    end

    state_e          state_q, state_d;
    logic            dbus_req_q, dbus_req_d;
    logic            dbus_we_q, dbus_we_d;
    logic [XLEN-1:0] dbus_addr_q, dbus_addr_d;
    logic [XLEN-1:0] dbus_wdata_q, dbus_wdata_d;
    logic [3:0]      dbus_be_q, dbus_be_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            exc_q, exc_d;
    logic [3:0]      exc_cause_q, exc_cause_d;
    logic [XLEN-1:0] exc_pc_q, exc_pc_d;
    logic [XLEN-1:0] exc_tval_q, exc_tval_d;

    logic            ex_done_s;
    logic            is_mem_s;
    logic            misaligned_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] ld_data_s;

    assign is_mem_s = ex_mem_load | ex_mem_store;

    rvee_mem_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (ex_result[1:0]),
        .size       (ex_mem_size),
        .sext       (ex_mem_sext),
        .st_data    (ex_mem_data),
        .rdata      (dbus_rdata),
        .misaligned (misaligned_s),
        .be         (be_s),
        .wdata      (wdata_s),
        .ld_data    (ld_data_s)
    );

    // Next-state, handshake and output-register computation.
    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_wdata_d = dbus_wdata_q;
        dbus_be_d    = dbus_be_q;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        exc_d        = 1'b0;
        exc_cause_d  = exc_cause_q;
        exc_pc_d     = exc_pc_q;
        exc_tval_d   = exc_tval_q;
        ex_done_s    = 1'b0;

        case (state_q)
            IDLE: begin
                // An instruction arriving alongside an exception pulse is younger: squash it.
                if (ex_valid && exc_q) begin
                    ex_done_s = 1'b1;
                end else if (ex_valid && !is_mem_s) begin
                    ex_done_s = 1'b1;
                    wb_we_d   = ex_rd_we;
                    wb_rd_d   = ex_rd;
                    wb_data_d = ex_result;
                end else if (ex_valid && misaligned_s) begin
                    ex_done_s   = 1'b1;
                    exc_d       = 1'b1;
                    exc_cause_d = mem_exc_cause(ex_mem_load, 1'b0);
                    exc_pc_d    = ex_pc;
                    exc_tval_d  = ex_result;
                end else if (ex_valid) begin
                    state_d      = BUS;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = ex_mem_store & ~ex_mem_load;
                    dbus_addr_d  = {ex_result[XLEN-1:2], 2'b00};
                    dbus_wdata_d = wdata_s;
                    dbus_be_d    = be_s;
                end else begin
                    ex_done_s = 1'b0;
                end
            end
            BUS: begin
                if (dbus_ack && dbus_err) begin
                    ex_done_s   = 1'b1;
                    state_d     = IDLE;
                    dbus_req_d  = 1'b0;
                    dbus_we_d   = 1'b0;
                    exc_d       = 1'b1;
                    exc_cause_d = mem_exc_cause(ex_mem_load, 1'b1);
                    exc_pc_d    = ex_pc;
                    exc_tval_d  = ex_result;
                end else if (dbus_ack && ex_mem_load) begin
                    ex_done_s  = 1'b1;
                    state_d    = IDLE;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    wb_we_d    = ex_rd_we;
                    wb_rd_d    = ex_rd;
                    wb_data_d  = ld_data_s;
                end else if (dbus_ack) begin
                    ex_done_s  = 1'b1;
                    state_d    = IDLE;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                end else begin
                    ex_done_s = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                dbus_req_d = 1'b0;
                dbus_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= {XLEN{1'b0}};
            dbus_wdata_q <= {XLEN{1'b0}};
            dbus_be_q    <= 4'b0000;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= {XLEN{1'b0}};
            exc_q        <= 1'b0;
            exc_cause_q  <= 4'd0;
            exc_pc_q     <= {XLEN{1'b0}};
            exc_tval_q   <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_wdata_q <= dbus_wdata_d;
            dbus_be_q    <= dbus_be_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            exc_q        <= exc_d;
            exc_cause_q  <= exc_cause_d;
            exc_pc_q     <= exc_pc_d;
            exc_tval_q   <= exc_tval_d;
        end
    end

    assign ex_done    = ex_done_s;
    assign ex_idle    = ~ex_valid | ex_done_s;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wdata = dbus_wdata_q;
    assign dbus_be    = dbus_be_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign exception  = exc_q;
    assign exc_cause  = exc_cause_q;
    assign exc_pc     = exc_pc_q;
    assign exc_tval   = exc_tval_q;

endmodule

// File: tb/tb_rvee_mem.sv
// Scoreboard bench for rvee_mem: directed instructions push expectations, a monitor pops and compares.
module tb_rvee_mem;
    import rvee_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_rd_we, ex_mem_load, ex_mem_store, ex_mem_sext;
    logic [31:0] ex_pc, ex_result, ex_mem_data;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_mem_size;
    logic        ex_done, ex_idle;
    logic        dbus_req, dbus_we, dbus_ack, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        wb_we, exception;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_pc, exc_tval;
    logic [3:0]  exc_cause;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic [3:0] cause; logic [31:0] pc; logic [31:0] tval; } exc_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
    wb_t  wb_q[$];
    exc_t exc_q[$];
    bus_t bus_q[$];

    rvee_mem #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_we(ex_rd_we), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_mem_data(ex_mem_data), .ex_mem_load(ex_mem_load),
        .ex_mem_store(ex_mem_store), .ex_mem_size(ex_mem_size), .ex_mem_sext(ex_mem_sext),
        .ex_done(ex_done), .ex_idle(ex_idle),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exception(exception), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents writeback, exception or a new request.
    logic req_prev = 1'b0;
    bus_t cur_bus;
    always @(negedge clk) begin
        wb_t  w;
        exc_t e;
        if (!rst) begin
            if (wb_we) begin
                if (wb_q.size() == 0) chk("wb_unexpected", {31'd0, wb_we}, 32'd0);
                else begin
                    w = wb_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
                    chk("wb_data", wb_data, w.data);
                end
            end
            if (exception) begin
                if (exc_q.size() == 0) chk("exc_unexpected", {31'd0, exception}, 32'd0);
                else begin
                    e = exc_q.pop_front();
                    chk("exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
                    chk("exc_pc", exc_pc, e.pc);
                    chk("exc_tval", exc_tval, e.tval);
                end
            end
            if (dbus_req && !req_prev) begin
                if (bus_q.size() == 0) chk("bus_unexpected", {31'd0, dbus_req}, 32'd0);
                else begin
                    cur_bus = bus_q.pop_front();
                    chk("bus_we", {31'd0, dbus_we}, {31'd0, cur_bus.we});
                    chk("bus_addr", dbus_addr, cur_bus.addr);
                    chk("bus_be", {28'd0, dbus_be}, {28'd0, cur_bus.be});
                    chk("bus_wdata", dbus_wdata, cur_bus.wdata);
                end
            end else if (dbus_req) begin
                chk("bus_hold_addr", dbus_addr, cur_bus.addr);
                chk("bus_hold_be", {28'd0, dbus_be}, {28'd0, cur_bus.be});
            end
        end
        req_prev <= dbus_req && !rst;
    end

    task automatic set_insn(input logic [31:0] pc, input logic rd_we, input logic [4:0] rd,
                            input logic [31:0] res, input logic [31:0] data, input logic ld,
                            input logic st, input logic [1:0] size, input logic sext);
        ex_valid = 1'b1; ex_pc = pc; ex_rd_we = rd_we; ex_rd = rd; ex_result = res;
        ex_mem_data = data; ex_mem_load = ld; ex_mem_store = st; ex_mem_size = size;
        ex_mem_sext = sext;
    endtask

    task automatic alu(input logic [31:0] pc, input logic rd_we, input logic [4:0] rd,
                       input logic [31:0] res);
        set_insn(pc, rd_we, rd, res, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        if (rd_we) wb_q.push_back('{rd, res});
        @(negedge clk);
        chk("alu_done", {31'd0, ex_done}, 32'd1);
        chk("alu_idle", {31'd0, ex_idle}, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Aligned memory op; ack arrives after lat extra BUS cycles.
    task automatic mem_op(input logic [31:0] pc, input logic ld, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size, input logic sext,
                          input int lat, input logic [31:0] rdata, input logic err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        set_insn(pc, 1'b1, 5'd10, addr, data, ld, !ld, size, sext);
        bus_q.push_back('{!ld, {addr[31:2], 2'b00}, exp_be, exp_wdata});
        if (err) exc_q.push_back('{ld ? EXC_LD_FAULT : EXC_ST_FAULT, pc, addr});
        else if (ld) wb_q.push_back('{5'd10, exp_wb});
        @(negedge clk);
        chk("mem_issue_done", {31'd0, ex_done}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("mem_wait_done", {31'd0, ex_done}, 32'd0);
            @(posedge clk); #1;
        end
        dbus_ack = 1'b1; dbus_rdata = rdata; dbus_err = err;
        @(negedge clk);
        chk("mem_ack_done", {31'd0, ex_done}, 32'd1);
        @(posedge clk); #1;
        dbus_ack = 1'b0; dbus_rdata = 32'd0; dbus_err = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk("mem_req_drop", {31'd0, dbus_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, dbus_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, dbus_we}, 32'd0);
        chk({tag, "_addr"}, dbus_addr, 32'd0);
        chk({tag, "_wdata"}, dbus_wdata, 32'd0);
        chk({tag, "_be"}, {28'd0, dbus_be}, 32'd0);
        chk({tag, "_wb_we"}, {31'd0, wb_we}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_exc"}, {31'd0, exception}, 32'd0);
        chk({tag, "_cause"}, {28'd0, exc_cause}, 32'd0);
        chk({tag, "_exc_pc"}, exc_pc, 32'd0);
        chk({tag, "_tval"}, exc_tval, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_pc = 32'd0; ex_rd_we = 1'b0; ex_rd = 5'd0;
        ex_result = 32'd0; ex_mem_data = 32'd0; ex_mem_load = 1'b0; ex_mem_store = 1'b0;
        ex_mem_size = 2'd0; ex_mem_sext = 1'b0;
        dbus_ack = 1'b0; dbus_rdata = 32'd0; dbus_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_idle", {31'd0, ex_idle}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back ALU instructions, one without rd write
        alu(32'h0000_0100, 1'b1, 5'd5, 32'h0000_1234);
        alu(32'h0000_0104, 1'b0, 5'd6, 32'h0000_CAFE);
        alu(32'h0000_0108, 1'b1, 5'd6, 32'h0000_BEEF);

        // Loads and stores: pc, load, addr, data, size, sext, lat, rdata, err, be, wdata, wb
        mem_op(32'h1000, 1'b1, 32'h103, 32'h0, 2'd0, 1'b1, 3, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        mem_op(32'h1004, 1'b1, 32'h103, 32'h0, 2'd0, 1'b0, 3, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0, 32'h0000_0080);
        mem_op(32'h1008, 1'b0, 32'h202, 32'h0000_ABCD, 2'd1, 1'b0, 1, 32'h0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        mem_op(32'h100C, 1'b1, 32'h102, 32'h0, 2'd1, 1'b1, 0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        mem_op(32'h1010, 1'b1, 32'h010, 32'h0, 2'd2, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        mem_op(32'h1014, 1'b1, 32'h001, 32'h0, 2'd0, 1'b0, 2, 32'h0000_A500, 1'b0, 4'b0010, 32'h0, 32'h0000_00A5);
        mem_op(32'h1018, 1'b0, 32'h020, 32'h1122_3344, 2'd3, 1'b0, 1, 32'h0, 1'b0, 4'b1111, 32'h1122_3344, 32'h0);
        mem_op(32'h101C, 1'b0, 32'h031, 32'h0000_0077, 2'd0, 1'b0, 0, 32'h0, 1'b0, 4'b0010, 32'h7777_7777, 32'h0);

        // Misaligned lw, then a younger instruction squashed in the exception cycle
        set_insn(32'h3000, 1'b1, 5'd3, 32'h301, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        exc_q.push_back('{EXC_LD_MISALIGN, 32'h3000, 32'h301});
        @(negedge clk);
        chk("mis_ld_done", {31'd0, ex_done}, 32'd1);
        @(posedge clk); #1;
        set_insn(32'h3004, 1'b1, 5'd7, 32'h55, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        chk("kill_done", {31'd0, ex_done}, 32'd1);
        chk("kill_exc", {31'd0, exception}, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("kill_no_wb", {31'd0, wb_we}, 32'd0);
        chk("exc_pulse", {31'd0, exception}, 32'd0);
        @(posedge clk); #1;

        // Misaligned sh
        set_insn(32'h3100, 1'b1, 5'd4, 32'h201, 32'h1234, 1'b0, 1'b1, 2'd1, 1'b0);
        exc_q.push_back('{EXC_ST_MISALIGN, 32'h3100, 32'h201});
        @(negedge clk);
        chk("mis_st_done", {31'd0, ex_done}, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;

        // Bus faults
        mem_op(32'h4000, 1'b0, 32'h400, 32'h0BAD_F00D, 2'd2, 1'b0, 1, 32'h0, 1'b1, 4'b1111, 32'h0BAD_F00D, 32'h0);
        mem_op(32'h4004, 1'b1, 32'h406, 32'h0, 2'd1, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 4'b1100, 32'h0, 32'h0);

        // Reset while the bus access is outstanding
        set_insn(32'h5000, 1'b1, 5'd1, 32'h500, 32'h0000_5A5A, 1'b0, 1'b1, 2'd2, 1'b0);
        bus_q.push_back('{1'b1, 32'h500, 4'b1111, 32'h0000_5A5A});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bus_before_rst", {31'd0, dbus_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midbus_rst");
        @(posedge clk); #1;

        alu(32'h6000, 1'b1, 5'd9, 32'h0000_0099);
        @(posedge clk); #1;

        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("exc_q_empty", exc_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
